// File: rtl/neopixel_pkg.sv
// Shared state encoding and default strand timing for the NeoPixel strand controller.
package neopixel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNAP,
    ST_FETCH,
    ST_HIGH,
    ST_LOW,
    ST_GAP
  } np_state_e;

  localparam int DEF_NUM_PIXELS = 16;
  localparam int DEF_T1H        = 35;
  localparam int DEF_T1L        = 30;
  localparam int DEF_T0H        = 18;
  localparam int DEF_T0L        = 40;
  localparam int DEF_TRST       = 2500;

endpackage

// File: rtl/np_bit_timer.sv
// Loadable down-counter that times high, low and latch-gap intervals.
module np_bit_timer #(
  parameter int W = 12
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc,
  output logic         pre_tc
);

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  // pre_tc lets the owner register an output that must coincide with the terminal cycle
  assign tc     = (count == '0);
  assign pre_tc = (count == W'(1));

endmodule

// File: rtl/neopixel_strand_controller.sv
// Double-buffered WS2812-style strand driver: user writes shadow, frames are sent from a snapshot.
module neopixel_strand_controller
  import neopixel_pkg::*;
#(
  parameter int NUM_PIXELS = DEF_NUM_PIXELS,
  parameter int T1H        = DEF_T1H,
  parameter int T1L        = DEF_T1L,
  parameter int T0H        = DEF_T0H,
  parameter int T0L        = DEF_T0L,
  parameter int TRST       = DEF_TRST,
  localparam int PIX_W     = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic [7:0]       red,
  input  logic [7:0]       green,
  input  logic [7:0]       blue,
  input  logic [PIX_W-1:0] pixel,
  input  logic             load,
  input  logic             fill,
  input  logic [7:0]       brightness,
  input  logic             go,
  output logic             neopixel_data,
  output logic             ready,
  output logic             frame_done
);

  localparam int TW = $clog2(TRST + 1);
  localparam logic [TW-1:0] T1H_M1  = TW'(T1H - 1);
  localparam logic [TW-1:0] T0H_M1  = TW'(T0H - 1);
  localparam logic [TW-1:0] T1L_M1  = TW'(T1L - 1);
  localparam logic [TW-1:0] T0L_M1  = TW'(T0L - 1);
  localparam logic [TW-1:0] T1L_M2  = TW'(T1L - 2);
  localparam logic [TW-1:0] T0L_M2  = TW'(T0L - 2);
  localparam logic [TW-1:0] TRST_M1 = TW'(TRST - 1);

  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'(c) * (16'(b) + 16'd1);
    return prod[15:8];
  endfunction

  logic [23:0]      shadow [NUM_PIXELS];
  logic [23:0]      active [NUM_PIXELS];
  np_state_e        state;
  logic             pending;
  logic [PIX_W-1:0] pix_idx;
  logic [4:0]       bit_idx;
  logic [23:0]      shreg;
  logic [23:0]      cur_px;
  logic [23:0]      fetch_word;
  logic             last_bit, last_pix, absorb;
  logic             tmr_load, tmr_tc, tmr_pre;
  logic [TW-1:0]    tmr_val;
  logic             in_range;

  assign in_range   = ({1'b0, pixel} < (PIX_W + 1)'(NUM_PIXELS));
  assign cur_px     = active[pix_idx];
  assign fetch_word = {scale_chan(cur_px[23:16], brightness),
                       scale_chan(cur_px[15:8],  brightness),
                       scale_chan(cur_px[7:0],   brightness)};
  assign last_bit   = (bit_idx == 5'd23);
  assign last_pix   = (pix_idx == PIX_W'(NUM_PIXELS - 1));
  // the final LOW of a pixel is one short so the FETCH cycle completes its bit period
  assign absorb     = last_bit && !last_pix;

  // Buffers stored as {G,R,B}; the SNAP copy sees shadow before any same-cycle write.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PIXELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (state == ST_SNAP) begin
        for (int i = 0; i < NUM_PIXELS; i++) active[i] <= shadow[i];
      end
      if (fill) begin
        for (int i = 0; i < NUM_PIXELS; i++) shadow[i] <= {green, red, blue};
      end else if (load && in_range) begin
        shadow[pixel] <= {green, red, blue};
      end
    end
  end

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_FETCH: begin
        tmr_load = 1'b1;
        tmr_val  = fetch_word[23] ? T1H_M1 : T0H_M1;
      end
      ST_HIGH: if (tmr_tc) begin
        tmr_load = 1'b1;
        if (shreg[23]) tmr_val = absorb ? T1L_M2 : T1L_M1;
        else           tmr_val = absorb ? T0L_M2 : T0L_M1;
      end
      ST_LOW: if (tmr_tc) begin
        if (!last_bit) begin
          tmr_load = 1'b1;
          tmr_val  = shreg[22] ? T1H_M1 : T0H_M1;
        end else if (last_pix) begin
          tmr_load = 1'b1;
          tmr_val  = TRST_M1;
        end
      end
      default: ;
    endcase
  end

  np_bit_timer #(.W(TW)) u_timer (
    .clock    (CLOCK_50),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc),
    .pre_tc   (tmr_pre)
  );

  // Reset lands in SNAP so a blank frame goes out automatically after release.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_SNAP;
      pending    <= 1'b0;
      pix_idx    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      neopixel_data <= 1'b0;
      ready      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pending    <= pending | go;
      ready      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pending) state <= ST_SNAP;
          else         ready <= ~go;
        end
        ST_SNAP: begin
          pending <= go;
          pix_idx <= '0;
          state   <= ST_FETCH;
        end
        ST_FETCH: begin
          shreg         <= fetch_word;
          bit_idx       <= '0;
          neopixel_data <= 1'b1;
          state         <= ST_HIGH;
        end
        ST_HIGH: if (tmr_tc) begin
          neopixel_data <= 1'b0;
          state         <= ST_LOW;
        end
        ST_LOW: if (tmr_tc) begin
          if (!last_bit) begin
            shreg         <= {shreg[22:0], 1'b0};
            bit_idx       <= bit_idx + 5'd1;
            neopixel_data <= 1'b1;
            state         <= ST_HIGH;
          end else if (!last_pix) begin
            pix_idx <= pix_idx + PIX_W'(1);
            state   <= ST_FETCH;
          end else begin
            frame_done <= (TRST == 1);
            state      <= ST_GAP;
          end
        end
        ST_GAP: begin
          frame_done <= tmr_pre;
          if (tmr_tc) begin
            if (pending) begin
              state <= ST_SNAP;
            end else begin
              state <= ST_IDLE;
              ready <= ~go;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neopixel_strand_controller.sv
// Directed bench: decodes the serial strand by pulse width and checks frames against hand-computed words.
module tb_neopixel_strand_controller;

  localparam int S_T1H = 6, S_T1L = 5, S_T0H = 3, S_T0L = 7, S_TRST = 40, S_NP = 5;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] red = 8'h00, green = 8'h00, blue = 8'h00, brightness = 8'hFF;
  logic [2:0] pixel = 3'd0;
  logic       load = 1'b0, fill = 1'b0, go = 1'b0;
  logic       d_s, rdy_s, fd_s;

  logic [7:0] z8 = 8'h00;
  logic [3:0] zpix = 4'd0;
  logic       z1 = 1'b0;
  logic       d_def, rdy_def, fd_def;

  int checks = 0;
  int errors = 0;
  bit use_def = 1'b0;
  logic [23:0] rx [16];
  int bad, tmo, gap_len, first_wait;

  always #10 clk = ~clk;

  neopixel_strand_controller #(
    .NUM_PIXELS(S_NP), .T1H(S_T1H), .T1L(S_T1L), .T0H(S_T0H), .T0L(S_T0L), .TRST(S_TRST)
  ) dut (
    .CLOCK_50(clk), .reset_n(reset_n), .red(red), .green(green), .blue(blue),
    .pixel(pixel), .load(load), .fill(fill), .brightness(brightness), .go(go),
    .neopixel_data(d_s), .ready(rdy_s), .frame_done(fd_s)
  );

  neopixel_strand_controller dut_def (
    .CLOCK_50(clk), .reset_n(reset_n), .red(z8), .green(z8), .blue(z8),
    .pixel(zpix), .load(z1), .fill(z1), .brightness(z8), .go(z1),
    .neopixel_data(d_def), .ready(rdy_def), .frame_done(fd_def)
  );

  function automatic logic cur_d();
    return use_def ? d_def : d_s;
  endfunction

  function automatic logic cur_fd();
    return use_def ? fd_def : fd_s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Returns on the sample where frame_done is seen high.
  task automatic capture(input int nbits, input int t1h, input int t0h, input int t1l, input int t0l);
    int hi, lo, w;
    bad = 0; tmo = 0; gap_len = 0; first_wait = -1;
    for (int i = 0; i < 16; i++) rx[i] = '0;
    for (int k = 0; k < nbits; k++) begin
      w = 0;
      while (cur_d() !== 1'b1 && w < 5000) begin @(negedge clk); w++; end
      if (k == 0) first_wait = w;
      if (w >= 5000) begin tmo = 1; return; end
      hi = 0;
      while (cur_d() === 1'b1 && hi < 5000) begin hi++; @(negedge clk); end
      lo = 0;
      if (k < nbits - 1) begin
        while (cur_d() === 1'b0 && lo < 5000) begin lo++; @(negedge clk); end
        if (!((hi == t1h && lo == t1l) || (hi == t0h && lo == t0l))) bad++;
      end else begin
        while (cur_fd() !== 1'b1 && cur_d() === 1'b0 && lo < 10000) begin lo++; @(negedge clk); end
        if (cur_fd() !== 1'b1) tmo = 1;
        gap_len = lo + 1;
        if (!(hi == t1h || hi == t0h)) bad++;
      end
      rx[k/24] = {rx[k/24][22:0], (hi == t1h)};
    end
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  initial begin
    int nbad, w;
    logic [23:0] acc;

    #5 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", d_s, 1'b0);
    chk("rst_ready", rdy_s, 1'b0);
    chk("rst_done", fd_s, 1'b0);
    chk("rst_def_ready", rdy_def, 1'b0);
    reset_n = 1'b1;

    // Blank frame from default-parameter instance: 384 zero bits, 40+2500 low tail
    use_def = 1'b1;
    capture(384, 35, 18, 30, 40);
    chk("def_timeout", tmo, 0);
    chk("def_bit_timing", bad, 0);
    acc = '0;
    for (int i = 0; i < 16; i++) acc = acc | rx[i];
    chk("def_all_zero", acc, 24'h0);
    chk("def_gap", gap_len, 2540);
    @(negedge clk);
    chk("def_ready_after", rdy_def, 1'b1);
    chk("def_done_one_cycle", fd_def, 1'b0);
    use_def = 1'b0;

    chk("small_ready_idle", rdy_s, 1'b1);

    // Load pixel 3 in the same cycle as go
    brightness = 8'hFF;
    red = 8'hFF; green = 8'h00; blue = 8'h80; pixel = 3'd3; load = 1'b1; go = 1'b1;
    @(negedge clk);
    load = 1'b0; go = 1'b0;
    chk("go_ready_low", rdy_s, 1'b0);
    capture(S_NP * 24, S_T1H, S_T0H, S_T1L, S_T0L);
    chk("p3_timeout", tmo, 0);
    chk("p3_timing", bad, 0);
    chk("p3_word", rx[3], 24'h00FF80);
    chk("p3_others_zero", rx[0] | rx[1] | rx[2] | rx[4], 24'h0);
    chk("p3_gap", gap_len, S_T0L + S_TRST);
    @(negedge clk);
    chk("p3_ready_after", rdy_s, 1'b1);

    // Fill with simultaneous load, then an out-of-range load, brightness 127
    red = 8'h40; green = 8'h40; blue = 8'h40; fill = 1'b1; load = 1'b1; pixel = 3'd1;
    @(negedge clk);
    fill = 1'b0; pixel = 3'd6; red = 8'hFF; green = 8'hFF; blue = 8'hFF;
    @(negedge clk);
    load = 1'b0; brightness = 8'd127;
    pulse_go();
    capture(S_NP * 24, S_T1H, S_T0H, S_T1L, S_T0L);
    chk("fill_timeout", tmo, 0);
    chk("fill_timing", bad, 0);
    chk("fill_px0", rx[0], 24'h202020);
    nbad = 0;
    for (int i = 0; i < S_NP; i++) if (rx[i] !== 24'h202020) nbad++;
    chk("fill_all_px", nbad, 0);
    chk("fill_gap", gap_len, S_T0L + S_TRST);

    // go and load pixel 0 during frame N: N unchanged, N+1 follows the gap directly
    @(negedge clk);
    brightness = 8'hFF;
    pulse_go();
    fork
      capture(S_NP * 24, S_T1H, S_T0H, S_T1L, S_T0L);
      begin
        repeat (300) @(negedge clk);
        red = 8'h11; green = 8'h22; blue = 8'h33; pixel = 3'd0; load = 1'b1; go = 1'b1;
        @(negedge clk);
        load = 1'b0; go = 1'b0;
      end
    join
    chk("n_timeout", tmo, 0);
    chk("n_timing", bad, 0);
    chk("n_px0_old", rx[0], 24'h404040);
    chk("n_px4", rx[4], 24'h404040);
    chk("n_ready_pending", rdy_s, 1'b0);
    capture(S_NP * 24, S_T1H, S_T0H, S_T1L, S_T0L);
    chk("n1_start_gap", first_wait, 3);
    chk("n1_timeout", tmo, 0);
    chk("n1_px0_new", rx[0], 24'h221133);
    chk("n1_px1", rx[1], 24'h404040);
    @(negedge clk);
    chk("n1_ready_after", rdy_s, 1'b1);

    // Reset pulsed during a high phase
    pulse_go();
    w = 0;
    while (d_s !== 1'b1 && w < 5000) begin @(negedge clk); w++; end
    chk("rst_pre_high", d_s, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_data", d_s, 1'b0);
    chk("rst_mid_ready", rdy_s, 1'b0);
    chk("rst_mid_done", fd_s, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    capture(S_NP * 24, S_T1H, S_T0H, S_T1L, S_T0L);
    chk("blank_timeout", tmo, 0);
    chk("blank_timing", bad, 0);
    chk("blank_zero", rx[0] | rx[1] | rx[2] | rx[3] | rx[4], 24'h0);
    chk("blank_gap", gap_len, S_T0L + S_TRST);
    @(negedge clk);
    chk("blank_ready_after", rdy_s, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
